// File: rtl/conv_encode.sv
// Rate-1/2, K=3 convolutional encoder emitting one 2-bit symbol per clock in 8-symbol byte frames.
// Latency: first symbol one edge after enable starts the stream; user bytes wait in a 2-entry FIFO.
// Backpressure: din_ready drops while the FIFO is full; an empty FIFO at a frame boundary sends FILL_BYTE.
module conv_encode #(
    parameter logic [2:0] G0        = 3'b111,
    parameter logic [2:0] G1        = 3'b101,
    parameter logic [7:0] FILL_BYTE = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [1:0] dout,
    output logic       dout_valid,
    output logic       frame_start,
    output logic       fill
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [2:0] bit_cnt;
    logic [1:0] enc_state;
    logic [7:0] frame_byte;
    logic       frame_fill;

    // Two-entry byte queue between the user side and the frame loader.
    logic [7:0] fifo_mem [2];
    logic       fifo_wr_ptr;
    logic       fifo_rd_ptr;
    logic [1:0] fifo_count;

    logic       push;
    logic       pop;
    logic       emit;
    logic       load;
    logic [7:0] cur_byte;
    logic       cur_fill;
    logic       cur_bit;
    logic [1:0] cur_state;
    logic [2:0] taps;
    logic       c0;
    logic       c1;

    logic [1:0] dout_next;
    logic       dout_valid_next;
    logic       frame_start_next;
    logic       fill_next;

    // Readiness depends on occupancy alone, so a pop never makes room in the same cycle.
    assign din_ready = (fifo_count != 2'd2);
    assign push      = din_valid && din_ready;

    // A frame byte is taken on the edge that emits counter value 0; the head is popped if present.
    assign emit      = (state == RUN);
    assign load      = emit && (bit_cnt == 3'd0);
    assign pop       = load && (fifo_count != 2'd0);

    // Symbol datapath: a new frame sees the freshly loaded byte with the shift state cleared.
    always_comb begin
        cur_byte  = frame_byte;
        cur_fill  = frame_fill;
        cur_state = enc_state;
        if (load) begin
            cur_byte  = (fifo_count != 2'd0) ? fifo_mem[fifo_rd_ptr] : FILL_BYTE;
            cur_fill  = (fifo_count == 2'd0);
            cur_state = 2'b00;
        end
        cur_bit = cur_byte[3'd7 - bit_cnt];
        taps    = {cur_bit, cur_state};
        c0      = ^(G0 & taps);
        c1      = ^(G1 & taps);
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a frame, once begun, always runs to its eighth symbol.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (enable) state_next = RUN;
            RUN:  if ((bit_cnt == 3'd7) && !enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: symbol and flags while running, all-zero while idle.
    always_comb begin
        dout_next        = 2'b00;
        dout_valid_next  = 1'b0;
        frame_start_next = 1'b0;
        fill_next        = 1'b0;
        if (emit) begin
            dout_next        = {c0, c1};
            dout_valid_next  = 1'b1;
            frame_start_next = (bit_cnt == 3'd0);
            fill_next        = cur_fill;
        end
    end

    // Registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dout        <= 2'b00;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
            fill        <= 1'b0;
        end else begin
            dout        <= dout_next;
            dout_valid  <= dout_valid_next;
            frame_start <= frame_start_next;
            fill        <= fill_next;
        end
    end

    // Bit counter, encoder shift state and the latched frame byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= 3'd0;
            enc_state  <= 2'b00;
            frame_byte <= 8'h00;
            frame_fill <= 1'b0;
        end else if (emit) begin
            bit_cnt   <= bit_cnt + 3'd1;
            enc_state <= {cur_bit, cur_state[1]};
            if (load) begin
                frame_byte <= cur_byte;
                frame_fill <= cur_fill;
            end
        end else begin
            bit_cnt   <= 3'd0;
            enc_state <= 2'b00;
        end
    end

    // Queue storage; contents are only meaningful under fifo_count, so no reset is needed.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[fifo_wr_ptr] <= din;
        end
    end

    // Queue pointers and occupancy; reset empties the queue immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) fifo_wr_ptr <= ~fifo_wr_ptr;
            if (pop)  fifo_rd_ptr <= ~fifo_rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encode.sv
module tb_conv_encode;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [1:0] dout;
    logic       dout_valid;
    logic       frame_start;
    logic       fill;

    int checks;
    int failures;

    conv_encode dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_start (frame_start),
        .fill        (fill)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One byte and its eight expected symbols, first symbol in bits [15:14].
    typedef struct {
        logic [7:0]  data;
        logic [15:0] syms;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle outputs.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Compare {dout_valid, frame_start, fill, dout} for symbol k of a frame.
    task automatic check_sym(input string name, input logic [15:0] syms, input int k, input logic fexp);
        logic [1:0] e;
        e = syms[15 - 2*k -: 2];
        check($sformatf("%s_k%0d", name, k),
              {11'd0, dout_valid, frame_start, fill, dout},
              {11'd0, 1'b1, (k == 0), fexp, e});
    endtask

    task automatic check_idle(input string name);
        check(name, {12'd0, dout_valid, frame_start, fill, dout}, 16'd0);
    endtask

    // Step through one full frame; enable is dropped after observing symbol drop_k.
    task automatic check_frame(input string name, input logic [15:0] syms, input logic fexp, input int drop_k);
        for (int k = 0; k < 8; k++) begin
            step();
            check_sym(name, syms, k, fexp);
            if (k == drop_k) enable = 1'b0;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        din       = b;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        enable    = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;

        vecs[0] = '{data: 8'hA5, syms: 16'hE2F8};
        vecs[1] = '{data: 8'hFF, syms: 16'hDAAA};
        vecs[2] = '{data: 8'h00, syms: 16'h0000};
        vecs[3] = '{data: 8'h80, syms: 16'hEC00};
        vecs[4] = '{data: 8'h01, syms: 16'h0003};
        vecs[5] = '{data: 8'h55, syms: 16'h3888};

        // Reset state.
        #12;
        check_idle("reset_outputs");
        reset = 1'b1;
        #1;
        check("reset_din_ready", {15'd0, din_ready}, 16'd1);
        step();
        check_idle("idle_after_reset");

        // Table of single frames pushed while idle.
        foreach (vecs[i]) begin
            push_byte(vecs[i].data);
            check($sformatf("v%0d_ready", i), {15'd0, din_ready}, 16'd1);
            enable = 1'b1;
            step();
            check_idle($sformatf("v%0d_latency", i));
            check_frame($sformatf("v%0d_%h", i, vecs[i].data), vecs[i].syms, 1'b0, 0);
            step();
            check_idle($sformatf("v%0d_end", i));
        end

        // Empty FIFO gives a fill frame; a byte pushed mid-frame follows as user data.
        enable = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            check_sym("fill_frame", 16'h0000, k, 1'b1);
            if (k == 3) begin
                din       = 8'hA5;
                din_valid = 1'b1;
            end
            if (k == 4) din_valid = 1'b0;
        end
        check_frame("after_fill", 16'hE2F8, 1'b0, 0);
        step();
        check_idle("after_fill_end");

        // Three back-to-back pushes: third waits for the first frame load; order kept.
        push_byte(8'hFF);
        check("b2b_ready1", {15'd0, din_ready}, 16'd1);
        push_byte(8'h80);
        check("b2b_ready2", {15'd0, din_ready}, 16'd0);
        din       = 8'h55;
        din_valid = 1'b1;
        enable    = 1'b1;
        step();
        check("b2b_ready_e0", {15'd0, din_ready}, 16'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            check_sym("b2b_f1", 16'hDAAA, k, 1'b0);
            if (k == 0) check("b2b_ready_after_load", {15'd0, din_ready}, 16'd1);
            if (k == 1) begin
                check("b2b_ready_after_3rd", {15'd0, din_ready}, 16'd0);
                din_valid = 1'b0;
            end
        end
        check_frame("b2b_f2", 16'hEC00, 1'b0, 8);
        check_frame("b2b_f3", 16'h3888, 1'b0, 0);
        step();
        check_idle("b2b_end");

        // Enable dropped mid-frame: the frame completes, then the block idles.
        push_byte(8'h80);
        enable = 1'b1;
        step();
        check_frame("drop_mid", 16'hEC00, 1'b0, 2);
        step();
        check_idle("drop_mid_end");
        step();
        check_idle("drop_mid_stay");

        // Reset mid-frame with two bytes queued aborts and flushes everything.
        push_byte(8'hA5);
        push_byte(8'hFF);
        enable = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            step();
            check_sym("pre_reset", 16'hE2F8, k, 1'b0);
        end
        #2;
        reset = 1'b0;
        #1;
        check_idle("mid_reset_outputs");
        check("mid_reset_ready", {15'd0, din_ready}, 16'd1);
        @(negedge clock);
        reset = 1'b1;
        step();
        check_idle("post_reset_latency");
        check_frame("post_reset_fill", 16'h0000, 1'b1, 0);
        step();
        check_idle("post_reset_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
